// File: rtl/score_display_ctrl.sv
// score_display_ctrl: converts a 20-bit score to six 7-segment digits with
// serial double-dabble and optional leading-zero blanking.
module score_display_ctrl #(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [19:0] score_i,
  input  logic        score_valid_i,
  output logic        score_ready_o,
  output logic        done_o,
  output logic [6:0]  hex0_o,
  output logic [6:0]  hex1_o,
  output logic [6:0]  hex2_o,
  output logic [6:0]  hex3_o,
  output logic [6:0]  hex4_o,
  output logic [6:0]  hex5_o
);
  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;
  state_t          r_state, w_next;
  logic [43:0]     r_shift;
  logic [4:0]      r_cnt;
  logic            r_done;
  logic [5:0][6:0] r_hex;
  logic [43:0]     w_adj;
  logic [43:0]     w_shift_nxt;
  logic [19:0]     w_sat;
  logic [5:0][6:0] w_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h18;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign w_sat = (score_i > 20'd999999) ? 20'd999999 : score_i;
  assign w_adj[19:0] = r_shift[19:0];
  assign w_shift_nxt = w_adj << 1;

  for (genvar g = 0; g < 6; g++) begin : g_dig
    logic [3:0] w_nib;
    logic       w_blank;
    assign w_nib = r_shift[20+4*g +: 4];
    assign w_adj[20+4*g +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
    // a digit blanks only when it and every more significant digit are zero
    assign w_blank = LZ_BLANK && (g != 0) && (r_shift[43:20+4*g] == '0);
    assign w_seg[g] = w_blank ? 7'h7F : seg7(w_nib);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = score_valid_i ? CONVERT : IDLE;
      CONVERT: w_next = (r_cnt == 5'd19) ? LOAD : CONVERT;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    score_ready_o = (r_state == IDLE);
    done_o        = r_done;
    {hex5_o, hex4_o, hex3_o, hex2_o, hex1_o, hex0_o} = r_hex;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hex   <= {6{7'h7F}};
    end else begin
      r_done <= (r_state == LOAD);
      if (r_state == IDLE && score_valid_i) begin
        r_shift <= {24'd0, w_sat};
        r_cnt   <= '0;
      end else if (r_state == CONVERT) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= (r_cnt == 5'd19) ? r_cnt : r_cnt + 5'd1;
      end
      if (r_state == LOAD) r_hex <= w_seg;
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed checks of both blanking variants sharing one stimulus.
module tb_score_display_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] score;
  logic        valid;
  logic        ready1, done1, ready0, done0;
  logic [6:0]  h10, h11, h12, h13, h14, h15;
  logic [6:0]  h00, h01, h02, h03, h04, h05;
  logic [41:0] hx1, hx0, old1;
  logic [19:0] last;
  int          vectors = 0;
  int          miscompares = 0;
  int          acc, dn;
  logic [6:0]  segt [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  always #5 clk = ~clk;

  assign hx1 = {h15, h14, h13, h12, h11, h10};
  assign hx0 = {h05, h04, h03, h02, h01, h00};

  score_display_ctrl #(.LZ_BLANK(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .score_i(score), .score_valid_i(valid),
    .score_ready_o(ready1), .done_o(done1),
    .hex0_o(h10), .hex1_o(h11), .hex2_o(h12), .hex3_o(h13), .hex4_o(h14), .hex5_o(h15));

  score_display_ctrl #(.LZ_BLANK(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .score_i(score), .score_valid_i(valid),
    .score_ready_o(ready0), .done_o(done0),
    .hex0_o(h00), .hex1_o(h01), .hex2_o(h02), .hex3_o(h03), .hex4_o(h04), .hex5_o(h05));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // decimal reference built from division, independent of the shift algorithm
  function automatic logic [41:0] model(input int v, input bit lz);
    int p;
    logic [41:0] r;
    if (v > 999999) v = 999999;
    p = 1;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      r[k*7 +: 7] = (lz && k > 0 && v < p) ? 7'h7F : segt[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic run(input string tag, input logic [19:0] s, input logic [41:0] e1, input logic [41:0] e0);
    @(negedge clk);
    score = s;
    valid = 1'b1;
    chk({tag, "_ready_in"}, ready1, 1'b1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    score = ~s;
    old1 = hx1;
    for (int c = 0; c < 21; c++) begin
      chk({tag, "_busy"}, {ready1, ready0, done1, done0}, 4'b0000);
      chk({tag, "_hold"}, hx1, old1);
      @(posedge clk);
      #1;
    end
    chk({tag, "_done"}, {done1, done0, ready1, ready0}, 4'b1111);
    chk({tag, "_hex_lz1"}, hx1, e1);
    chk({tag, "_hex_lz0"}, hx0, e0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {done1, done0}, 2'b00);
    chk({tag, "_hex_kept"}, hx1, e1);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    score = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {ready1, ready0}, 2'b11);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_hex1", hx1, {6{7'h7F}});
    chk("rst_hex0", hx0, {6{7'h7F}});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_no_accept", ready1, 1'b1);

    run("zero", 20'd0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, {6{7'h40}});
    run("s123456", 20'd123456, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02},
        {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    run("sat", 20'hFFFFF, {6{7'h18}}, {6{7'h18}});
    run("s1005", 20'd1005, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h12},
        {7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h12});

    @(negedge clk);
    score = 20'd777777;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_hex1", hx1, {6{7'h7F}});
    chk("abort_hex0", hx0, {6{7'h7F}});
    chk("abort_state", {ready1, done1}, 2'b10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done1 || done0) dn++;
    end
    chk("abort_nodone", dn, 0);
    chk("abort_hex_after", hx1, {6{7'h7F}});
    run("s42", 20'd42, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24},
        {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});

    acc = 0;
    dn = 0;
    last = '0;
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      score = 20'(i * 7919 + 1000);
      valid = 1'b1;
      if (ready1) begin
        last = score;
        acc++;
      end
      @(posedge clk);
      #1;
      if (done1) begin
        dn++;
        chk("stream_hex_lz1", hx1, model(int'(last), 1'b1));
        chk("stream_hex_lz0", hx0, model(int'(last), 1'b0));
      end
    end
    @(negedge clk);
    valid = 1'b0;
    chk("stream_accepts", acc, 3);
    chk("stream_dones", dn, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
